// File: rtl/range_merge_pkg.sv
// Shared types for the range merge sequencer: value width, stored pair layout, FSM states.
// Latency: n/a (types and one pure function only).
// Backpressure: n/a.
package range_merge_pkg;

  // Decoded value width; the top-level RANGE_WIDTH parameter must match this.
  localparam int RANGE_W = 64;

  typedef logic [RANGE_W-1:0] range_t;

  typedef struct packed {
    range_t lo;
    range_t hi;
  } range_pair_t;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    SORT    = 2'd1,
    MERGE   = 2'd2,
    DONE    = 2'd3
  } state_t;

  // One bit wider than a value so the full 0..2^W-1 span (2^W IDs) fits.
  typedef logic [RANGE_W:0] count_t;

  // Number of IDs in an inclusive range; callers guarantee lo <= hi.
  function automatic count_t span(range_pair_t p);
    return {1'b0, p.hi} - {1'b0, p.lo} + count_t'(1);
  endfunction

endpackage

// File: rtl/range_merge_sequencer_table.sv
// Range table: DEPTH x {lo,hi} register array, one write/swap port, reads at idx and idx+1.
// Latency: reads combinational, writes and swaps land on the next rising edge.
// Backpressure: none; a write takes priority over a swap in the same cycle.
module range_pair_table
  import range_merge_pkg::*;
#(
  parameter int DEPTH     = 256,
  parameter int IDX_WIDTH = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [IDX_WIDTH-1:0] wr_idx,
  input  range_pair_t          wr_dat,
  input  logic                 swap_en,
  input  logic [IDX_WIDTH-1:0] rd_idx,
  output range_pair_t          rd0,
  output range_pair_t          rd1
);

  range_pair_t mem [DEPTH];
  logic [IDX_WIDTH-1:0] nxt_idx;

  assign nxt_idx = rd_idx + IDX_WIDTH'(1);

  // Combinational reads; the +1 port reads zero past the end of the array.
  always_comb begin
    rd0 = mem[rd_idx];
    rd1 = '0;
    if (int'(nxt_idx) < DEPTH) rd1 = mem[nxt_idx];
  end

  // Contents carry no reset: the length register in the top marks what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_dat;
    end else if (swap_en) begin
      mem[rd_idx]  <= rd1;
      mem[nxt_idx] <= rd0;
    end
  end

endmodule

// File: rtl/range_merge_sequencer.sv
// Pairs decoded values into [lo,hi] ranges, bubble-sorts them by lo, merges, counts union size.
// Latency: EOF cycle to done <= 1 + (len-1)^2 + len + 1 cycles; RANGE_SORT_EARLY_EXIT_EN ends sort on a clean pass.
// Backpressure: none; every range_valid strobe in COLLECT is consumed in its cycle.
module range_merge_sequencer
  import range_merge_pkg::*;
#(
  parameter int RANGE_WIDTH = 64,
  parameter int DEPTH       = 256,
  parameter int IDX_WIDTH   = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 range_valid,
  input  logic [RANGE_WIDTH-1:0] range_data,
  input  logic                 end_of_file,
  output logic                 busy,
  output logic                 done,
  output logic [RANGE_WIDTH:0] total_count,
  output logic [IDX_WIDTH:0]   range_count,
  output logic                 overflow,
  output logic                 odd_error
);

  localparam logic [IDX_WIDTH:0] CNT_ONE   = (IDX_WIDTH+1)'(1);
  localparam logic [IDX_WIDTH:0] CNT_TWO   = (IDX_WIDTH+1)'(2);
  localparam logic [IDX_WIDTH:0] CNT_DEPTH = (IDX_WIDTH+1)'(DEPTH);

  state_t state, state_nxt;

  logic               phase;      // 0: expecting lo, 1: expecting hi
  range_t             lo_hold;
  logic [IDX_WIDTH:0] cnt;
  logic [IDX_WIDTH:0] idx;        // sort compare index / merge read index
  logic [IDX_WIDTH:0] pass_cnt;
  range_pair_t        cur;
  count_t             acc;
  count_t             total_q;
  logic               ovf_q;
  logic               odd_q;

  range_pair_t rd0, rd1, wr_dat;
  logic        pair_done, table_full, wr_en, swap_en, swap_this;
  logic        phase_after, pass_end, last_pass, early, sort_finish, merge_finish;
  range_t      din;

  assign din = range_t'(range_data);

  // Collect-side pairing and ordering of each incoming pair.
  always_comb begin
    pair_done   = (state == COLLECT) && range_valid && phase;
    table_full  = (cnt == CNT_DEPTH);
    wr_en       = pair_done && !table_full;
    phase_after = range_valid ? ~phase : phase;
    wr_dat      = (din < lo_hold) ? '{lo: din, hi: lo_hold} : '{lo: lo_hold, hi: din};
  end

`ifdef RANGE_SORT_EARLY_EXIT_EN
  logic swapped;
  assign early = !(swapped || swap_this);
`else
  assign early = 1'b0;
`endif

  // Sort and merge sequencing conditions.
  always_comb begin
    swap_this    = (rd0.lo > rd1.lo);
    pass_end     = (idx == cnt - CNT_TWO);
    last_pass    = (pass_cnt == cnt - CNT_TWO);
    sort_finish  = (cnt <= CNT_ONE) || (pass_end && (last_pass || early));
    swap_en      = (state == SORT) && (cnt > CNT_ONE) && swap_this;
    merge_finish = (idx == cnt);
  end

  range_pair_table #(.DEPTH(DEPTH), .IDX_WIDTH(IDX_WIDTH)) u_table (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_idx  (cnt[IDX_WIDTH-1:0]),
    .wr_dat  (wr_dat),
    .swap_en (swap_en),
    .rd_idx  (idx[IDX_WIDTH-1:0]),
    .rd0     (rd0),
    .rd1     (rd1)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= COLLECT;
    else     state <= state_nxt;
  end

  // Next state and status outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      COLLECT: if (end_of_file) state_nxt = SORT;
      SORT: begin
        busy = 1'b1;
        if (sort_finish) state_nxt = MERGE;
      end
      MERGE: begin
        busy = 1'b1;
        if (merge_finish) state_nxt = DONE;
      end
      DONE: done = 1'b1;
      default: state_nxt = COLLECT;
    endcase
  end

  // Datapath: pairing, sort indices, merge accumulator, sticky flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase    <= 1'b0;
      lo_hold  <= '0;
      cnt      <= '0;
      idx      <= '0;
      pass_cnt <= '0;
      cur      <= '0;
      acc      <= '0;
      total_q  <= '0;
      ovf_q    <= 1'b0;
      odd_q    <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (range_valid) begin
            if (!phase) begin
              lo_hold <= din;
              phase   <= 1'b1;
            end else begin
              phase <= 1'b0;
              if (table_full) ovf_q <= 1'b1;
              else            cnt   <= cnt + CNT_ONE;
            end
          end
          // A strobe in the EOF cycle is handled above; a dangling lo is dropped here.
          if (end_of_file) begin
            if (phase_after) odd_q <= 1'b1;
            phase    <= 1'b0;
            idx      <= '0;
            pass_cnt <= '0;
          end
        end
        SORT: begin
          if (cnt > CNT_ONE) begin
            if (pass_end) begin
              idx      <= '0;
              pass_cnt <= pass_cnt + CNT_ONE;
            end else begin
              idx <= idx + CNT_ONE;
            end
          end
          if (sort_finish) idx <= '0;
        end
        MERGE: begin
          if (merge_finish) begin
            total_q <= (cnt == '0) ? '0 : acc + span(cur);
          end else if (idx == '0) begin
            cur <= rd0;
            idx <= CNT_ONE;
          end else begin
            if (rd0.lo <= cur.hi) begin
              if (rd0.hi > cur.hi) cur.hi <= rd0.hi;
            end else begin
              acc <= acc + span(cur);
              cur <= rd0;
            end
            idx <= idx + CNT_ONE;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef RANGE_SORT_EARLY_EXIT_EN
  // Per-pass swap flag, cleared at EOF and at every pass boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      swapped <= 1'b0;
    end else if (state == COLLECT) begin
      swapped <= 1'b0;
    end else if (state == SORT && cnt > CNT_ONE) begin
      if (pass_end) swapped <= 1'b0;
      else          swapped <= swapped | swap_this;
    end
  end
`endif

  assign total_count = total_q;
  assign range_count = cnt;
  assign overflow    = ovf_q;
  assign odd_error   = odd_q;

endmodule

// File: tb/tb_range_merge_sequencer.sv
// Directed bench for range_merge_sequencer with a small table (DEPTH=8).
// Latency: checks the EOF-to-done bound and the early-exit speedup when enabled.
// Backpressure: n/a; strobes are driven at most every other cycle.
module tb_range_merge_sequencer;

  localparam int RW    = 64;
  localparam int DEPTH = 8;
  localparam int IW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          range_valid = 1'b0;
  logic [RW-1:0] range_data = '0;
  logic          end_of_file = 1'b0;
  logic          busy, done, overflow, odd_error;
  logic [RW:0]   total_count;
  logic [IW:0]   range_count;

  int vectors = 0;
  int miscompares = 0;
  int cyc_rev, cyc_sorted, cyc_tmp;
  logic [RW-1:0] rev_lo [8];
  logic [RW-1:0] rev_hi [8];

  always #5 clk = ~clk;

  range_merge_sequencer #(.RANGE_WIDTH(RW), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .range_valid (range_valid),
    .range_data  (range_data),
    .end_of_file (end_of_file),
    .busy        (busy),
    .done        (done),
    .total_count (total_count),
    .range_count (range_count),
    .overflow    (overflow),
    .odd_error   (odd_error)
  );

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " busy"}, 80'(busy), 80'd0);
    chk({tag, " done"}, 80'(done), 80'd0);
    chk({tag, " total"}, 80'(total_count), 80'd0);
    chk({tag, " rcount"}, 80'(range_count), 80'd0);
    chk({tag, " ovf"}, 80'(overflow), 80'd0);
    chk({tag, " odd"}, 80'(odd_error), 80'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    range_valid = 1'b0;
    end_of_file = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic send(input logic [RW-1:0] v);
    @(posedge clk); #1;
    range_valid = 1'b1;
    range_data  = v;
    @(posedge clk); #1;
    range_valid = 1'b0;
  endtask

  task automatic send_pair(input logic [RW-1:0] lo, input logic [RW-1:0] hi);
    send(lo);
    send(hi);
  endtask

  // Raises EOF after the next edge and counts edges until done, bounded.
  task automatic eof_and_wait(input string tag, output int cycles);
    @(posedge clk); #1;
    end_of_file = 1'b1;
    cycles = 0;
    while (cycles < 300) begin
      @(posedge clk); #1;
      cycles++;
      if (done) break;
    end
    chk({tag, " done"}, 80'(done), 80'd1);
    chk({tag, " busy"}, 80'(busy), 80'd0);
  endtask

  initial begin
    for (int k = 0; k < 8; k++) begin
      rev_lo[k] = RW'(70 - 10 * k);
      rev_hi[k] = RW'(70 - 10 * k + 1 + k);
    end

    // Reset state
    #2;
    chk_idle("reset");
    do_reset();

    // Overlapping ranges out of order: [3,5] + [10,20] -> 3 + 11
    send_pair(64'd3, 64'd5);
    send_pair(64'd10, 64'd14);
    send_pair(64'd16, 64'd20);
    send_pair(64'd12, 64'd18);
    chk("t1 pre busy", 80'(busy), 80'd0);
    eof_and_wait("t1", cyc_tmp);
    chk("t1 rcount", 80'(range_count), 80'd4);
    chk("t1 total", 80'(total_count), 80'd14);
    chk("t1 ovf", 80'(overflow), 80'd0);
    chk("t1 odd", 80'(odd_error), 80'd0);
    chk("t1 latency<=15", 80'(cyc_tmp <= 15), 80'd1);

    // Adjacent and single-point ranges
    do_reset();
    send_pair(64'd1, 64'd2);
    send_pair(64'd3, 64'd4);
    send_pair(64'd10, 64'd10);
    eof_and_wait("t2", cyc_tmp);
    chk("t2 rcount", 80'(range_count), 80'd3);
    chk("t2 total", 80'(total_count), 80'd5);

    // Nested and identical ranges
    do_reset();
    send_pair(64'd1, 64'd100);
    send_pair(64'd20, 64'd30);
    send_pair(64'd1, 64'd100);
    send_pair(64'd50, 64'd150);
    eof_and_wait("t3", cyc_tmp);
    chk("t3 total", 80'(total_count), 80'd150);

    // Overflow: DEPTH+1 pairs of [1,1]
    do_reset();
    for (int k = 0; k < DEPTH + 1; k++) send_pair(64'd1, 64'd1);
    eof_and_wait("t4", cyc_tmp);
    chk("t4 ovf", 80'(overflow), 80'd1);
    chk("t4 rcount", 80'(range_count), 80'(DEPTH));
    chk("t4 total", 80'(total_count), 80'd1);
    chk("t4 odd", 80'(odd_error), 80'd0);

    // Unpaired lo at EOF
    do_reset();
    send(64'd7);
    send(64'd9);
    send(64'd4);
    eof_and_wait("t5", cyc_tmp);
    chk("t5 odd", 80'(odd_error), 80'd1);
    chk("t5 rcount", 80'(range_count), 80'd1);
    chk("t5 total", 80'(total_count), 80'd3);

    // Reversed pair whose hi strobe coincides with EOF: [11,20] -> 10
    do_reset();
    send(64'd20);
    @(posedge clk); #1;
    range_valid = 1'b1;
    range_data  = 64'd11;
    end_of_file = 1'b1;
    @(posedge clk); #1;
    range_valid = 1'b0;
    cyc_tmp = 0;
    while (!done && cyc_tmp < 50) begin
      @(posedge clk); #1;
      cyc_tmp++;
    end
    chk("t5b done", 80'(done), 80'd1);
    chk("t5b rcount", 80'(range_count), 80'd1);
    chk("t5b total", 80'(total_count), 80'd10);
    chk("t5b odd", 80'(odd_error), 80'd0);

    // EOF with no ranges
    do_reset();
    eof_and_wait("t6", cyc_tmp);
    chk("t6 total", 80'(total_count), 80'd0);
    chk("t6 rcount", 80'(range_count), 80'd0);

    // Reverse-sorted 8 disjoint ranges, reset mid-SORT, then replay: 2+3+...+9 = 44
    do_reset();
    for (int k = 0; k < 8; k++) send_pair(rev_lo[k], rev_hi[k]);
    @(posedge clk); #1;
    end_of_file = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("t7 mid busy", 80'(busy), 80'd1);
    rst = 1'b1;
    end_of_file = 1'b0;
    #2;
    chk_idle("t7 in reset");
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 8; k++) send_pair(rev_lo[k], rev_hi[k]);
    eof_and_wait("t7", cyc_rev);
    chk("t7 rcount", 80'(range_count), 80'd8);
    chk("t7 total", 80'(total_count), 80'd44);
    chk("t7 latency<=59", 80'(cyc_rev <= 59), 80'd1);

    // Same ranges presorted
    do_reset();
    for (int k = 7; k >= 0; k--) send_pair(rev_lo[k], rev_hi[k]);
    eof_and_wait("t8", cyc_sorted);
    chk("t8 total", 80'(total_count), 80'd44);
`ifdef RANGE_SORT_EARLY_EXIT_EN
    chk("t8 sorted faster", 80'(cyc_sorted < cyc_rev), 80'd1);
`else
    chk("t8 latency data-independent", 80'(cyc_sorted), 80'(cyc_rev));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
